// File: rtl/pipeline_stall_controller_if.sv
// Bundle of hazard/branch/memory inputs and freeze/flush/performance outputs
// exchanged between the stall controller and the rest of the pipeline.
interface pipeline_stall_controller_if #(
  parameter int unsigned CNT_W = 16
);
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_access;
  logic             mem_ready;
  logic             cfg_fwd_req;
  logic             cfg_fwd_val;
  logic             cnt_clear;
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             flush_if_id;
  logic             bubble_id_exe;
  logic             freeze_backend;
  logic             with_forwarding;
  logic             busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Controller side: consumes pipeline status, drives stage controls.
  modport master (
    input  hazard_detected, branch_taken, mem_access, mem_ready,
           cfg_fwd_req, cfg_fwd_val, cnt_clear,
    output freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe,
           freeze_backend, with_forwarding, busy, stall_count, flush_count
  );

  // Pipeline side: drives status, consumes stage controls.
  modport slave (
    output hazard_detected, branch_taken, mem_access, mem_ready,
           cfg_fwd_req, cfg_fwd_val, cnt_clear,
    input  freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe,
           freeze_backend, with_forwarding, busy, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. Control outputs are a
// Mealy function of the state and the current hazard/branch/memory inputs;
// the forwarding-mode bit only changes after a fixed number of drain bubbles.
module pipeline_stall_controller #(
  parameter int unsigned RESET_HOLD   = 2,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16,
  parameter bit          FWD_RESET    = 1'b1
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_stall_controller_if.master  bus
);

  localparam int unsigned HOLD_W  = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               pend_q, pend_d;
  logic               fwd_q, fwd_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;

  logic mem_stall_s;
  logic do_run_s;
  logic do_drain_s;
  logic allow_cfg_s;
  logic fp_s, fi_s, fl_s, bub_s, fb_s;
  logic flush_inc_s;
  logic stall_inc_s;

  assign mem_stall_s = bus.mem_access & ~bus.mem_ready;

  // Next-state, register updates and Mealy control outputs.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    hold_d      = hold_q;
    drain_d     = drain_q;
    pend_d      = pend_q;
    fwd_d       = fwd_q;
    do_run_s    = 1'b0;
    do_drain_s  = 1'b0;
    allow_cfg_s = 1'b0;
    fp_s        = 1'b0;
    fi_s        = 1'b0;
    fl_s        = 1'b0;
    bub_s       = 1'b0;
    fb_s        = 1'b0;
    flush_inc_s = 1'b0;

    case (state_q)
      ST_INIT: begin
        fp_s  = 1'b1;
        fi_s  = 1'b1;
        bub_s = 1'b1;
        if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        do_run_s    = 1'b1;
        allow_cfg_s = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (mem_stall_s) begin
          fp_s = 1'b1;
          fi_s = 1'b1;
          fb_s = 1'b1;
        end else begin
          // The completing cycle already belongs to the state we return to,
          // but a mode request arriving now is dropped rather than queued.
          state_d = ret_q;
          if (ret_q == ST_DRAIN) begin
            do_drain_s = 1'b1;
          end else begin
            do_run_s = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        do_drain_s = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (do_run_s) begin
      if (mem_stall_s) begin
        fp_s    = 1'b1;
        fi_s    = 1'b1;
        fb_s    = 1'b1;
        ret_d   = ST_RUN;
        state_d = ST_MEM_WAIT;
      end else if (bus.branch_taken) begin
        // Wrong-path instruction in ID: squash it even if it also hazards.
        fl_s        = 1'b1;
        bub_s       = 1'b1;
        flush_inc_s = 1'b1;
      end else if (bus.hazard_detected) begin
        fp_s  = 1'b1;
        fi_s  = 1'b1;
        bub_s = 1'b1;
      end else if (allow_cfg_s && bus.cfg_fwd_req && (bus.cfg_fwd_val != fwd_q)) begin
        pend_d  = bus.cfg_fwd_val;
        drain_d = DRAIN_W'(DRAIN_CYCLES);
        state_d = ST_DRAIN;
      end else begin
        state_d = state_d;
      end
    end else if (do_drain_s) begin
      if (mem_stall_s) begin
        // Drain progress is frozen together with the memory stage.
        fp_s    = 1'b1;
        fi_s    = 1'b1;
        fb_s    = 1'b1;
        ret_d   = ST_DRAIN;
        state_d = ST_MEM_WAIT;
      end else begin
        if (bus.branch_taken) begin
          fl_s        = 1'b1;
          bub_s       = 1'b1;
          flush_inc_s = 1'b1;
        end else begin
          fp_s  = 1'b1;
          fi_s  = 1'b1;
          bub_s = 1'b1;
        end
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q == DRAIN_W'(1)) begin
          fwd_d   = pend_q;
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
    end else begin
      state_d = state_d;
    end
  end

  assign stall_inc_s = fp_s & (state_q != ST_INIT);

  // Saturating performance counters; clear wins over increment.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (bus.cnt_clear) begin
      stall_d = {CNT_W{1'b0}};
      flush_d = {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_q != {CNT_W{1'b1}})) begin
        stall_d = stall_q + CNT_W'(1);
      end else begin
        stall_d = stall_q;
      end
      if (flush_inc_s && (flush_q != {CNT_W{1'b1}})) begin
        flush_d = flush_q + CNT_W'(1);
      end else begin
        flush_d = flush_q;
      end
    end
  end

  // State and datapath registers; reset abandons any drain or memory wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      ret_q   <= ST_RUN;
      hold_q  <= {HOLD_W{1'b0}};
      drain_q <= {DRAIN_W{1'b0}};
      pend_q  <= 1'b0;
      fwd_q   <= FWD_RESET;
      stall_q <= {CNT_W{1'b0}};
      flush_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      pend_q  <= pend_d;
      fwd_q   <= fwd_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.freeze_pc       = fp_s;
  assign bus.freeze_if_id    = fi_s;
  assign bus.flush_if_id     = fl_s;
  assign bus.bubble_id_exe   = bub_s;
  assign bus.freeze_backend  = fb_s;
  assign bus.with_forwarding = fwd_q;
  assign bus.busy            = (state_q != ST_RUN);
  assign bus.stall_count     = stall_q;
  assign bus.flush_count     = flush_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: the stimulus process computes expected outputs from a
// rule-level model and queues them; a monitor compares them to the DUT.
module tb_pipeline_stall_controller;

  localparam int unsigned RESET_HOLD   = 2;
  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned CNT_W        = 4;
  localparam bit          FWD_RESET    = 1'b1;
  localparam int unsigned SAT          = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             fp;
    logic             fi;
    logic             fl;
    logic             bub;
    logic             fb;
    logic             fwd;
    logic             busy;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   stim_done;
  exp_t exp_q[$];

  pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus_i ();

  pipeline_stall_controller #(
    .RESET_HOLD  (RESET_HOLD),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .CNT_W       (CNT_W),
    .FWD_RESET   (FWD_RESET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycles since reset, whether a memory wait is open,
  // how many drain bubbles remain, the pending mode, and counter values.
  int unsigned m_since;
  bit          m_in_wait;
  int unsigned m_left;
  bit          m_pend;
  bit          m_fwd;
  int unsigned m_sc;
  int unsigned m_fc;

  task automatic model_reset();
    m_since   = 0;
    m_in_wait = 1'b0;
    m_left    = 0;
    m_pend    = 1'b0;
    m_fwd     = FWD_RESET;
    m_sc      = 0;
    m_fc      = 0;
  endtask

  task automatic model_step(input bit r, input bit hz, input bit br, input bit ma,
                            input bit mr, input bit req, input bit val, input bit clr,
                            output exp_t e);
    bit ms, was_wait, was_drain, s_inc, f_inc;
    e     = '0;
    s_inc = 1'b0;
    f_inc = 1'b0;
    if (!r) begin
      model_reset();
      e.fp = 1'b1; e.fi = 1'b1; e.bub = 1'b1; e.busy = 1'b1; e.fwd = FWD_RESET;
    end else begin
      e.fwd = m_fwd;
      e.sc  = m_sc[CNT_W-1:0];
      e.fc  = m_fc[CNT_W-1:0];
      ms    = ma && !mr;
      if (m_since < RESET_HOLD) begin
        e.fp = 1'b1; e.fi = 1'b1; e.bub = 1'b1; e.busy = 1'b1;
        m_since++;
      end else begin
        was_wait  = m_in_wait;
        was_drain = (m_left != 0);
        e.busy    = was_wait || was_drain;
        if (ms) begin
          e.fp = 1'b1; e.fi = 1'b1; e.fb = 1'b1;
          m_in_wait = 1'b1;
        end else begin
          m_in_wait = 1'b0;
          if (was_drain) begin
            if (br) begin
              e.fl = 1'b1; e.bub = 1'b1; f_inc = 1'b1;
            end else begin
              e.fp = 1'b1; e.fi = 1'b1; e.bub = 1'b1;
            end
            m_left--;
            if (m_left == 0) m_fwd = m_pend;
          end else if (br) begin
            e.fl = 1'b1; e.bub = 1'b1; f_inc = 1'b1;
          end else if (hz) begin
            e.fp = 1'b1; e.fi = 1'b1; e.bub = 1'b1;
          end else if (!was_wait && req && (val != m_fwd)) begin
            m_pend = val;
            m_left = DRAIN_CYCLES;
          end
        end
        s_inc = e.fp;
      end
      if (clr) begin
        m_sc = 0;
        m_fc = 0;
      end else begin
        if (s_inc && m_sc < SAT) m_sc++;
        if (f_inc && m_fc < SAT) m_fc++;
      end
    end
  endtask

  // One stimulus cycle: drive inputs after the falling edge and queue the
  // response the model expects for this cycle.
  task automatic cyc(input bit r, input bit hz, input bit br, input bit ma,
                     input bit mr, input bit req, input bit val, input bit clr);
    exp_t e;
    @(negedge clk);
    rst                   = r;
    bus_i.hazard_detected = hz;
    bus_i.branch_taken    = br;
    bus_i.mem_access      = ma;
    bus_i.mem_ready       = mr;
    bus_i.cfg_fwd_req     = req;
    bus_i.cfg_fwd_val     = val;
    bus_i.cnt_clear       = clr;
    model_step(r, hz, br, ma, mr, req, val, clr, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pop one expectation per cycle and compare away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin
        if (!stim_done) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
        end
      end else begin
        e = exp_q.pop_front();
        total++;
        if ({bus_i.freeze_pc, bus_i.freeze_if_id, bus_i.flush_if_id, bus_i.bubble_id_exe,
             bus_i.freeze_backend} !== {e.fp, e.fi, e.fl, e.bub, e.fb}) begin
          bad++;
          $display("FAIL controls at %0t: got %b required %b (pc,ifid,flush,bubble,backend)", $time,
                   {bus_i.freeze_pc, bus_i.freeze_if_id, bus_i.flush_if_id, bus_i.bubble_id_exe,
                    bus_i.freeze_backend}, {e.fp, e.fi, e.fl, e.bub, e.fb});
        end
        total++;
        if ({bus_i.with_forwarding, bus_i.busy} !== {e.fwd, e.busy}) begin
          bad++;
          $display("FAIL fwd_busy at %0t: got %b required %b", $time,
                   {bus_i.with_forwarding, bus_i.busy}, {e.fwd, e.busy});
        end
        total++;
        if ({bus_i.stall_count, bus_i.flush_count} !== {e.sc, e.fc}) begin
          bad++;
          $display("FAIL counters at %0t: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                   $time, bus_i.stall_count, bus_i.flush_count, e.sc, e.fc);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    total     = 0;
    bad       = 0;
    stim_done = 1'b0;
    rst                   = 1'b0;
    bus_i.hazard_detected = 1'b0;
    bus_i.branch_taken    = 1'b0;
    bus_i.mem_access      = 1'b0;
    bus_i.mem_ready       = 1'b0;
    bus_i.cfg_fwd_req     = 1'b0;
    bus_i.cfg_fwd_val     = 1'b0;
    bus_i.cnt_clear       = 1'b0;
    model_reset();

    // reset and hold
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    // hazard, then hazard together with branch
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // three-cycle memory wait
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    // mode switch to 0, then a redundant request
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // mode switch to 1 with a 2-cycle memory stall in drain cycle 2
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    // branch during drain
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // counter saturation and clear
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // reset in the middle of a drain
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, hz, br, ma, mr, req, val, clr;
      r   = ($urandom_range(0, 299) != 0);
      hz  = ($urandom_range(0, 99) < 20);
      br  = ($urandom_range(0, 99) < 12);
      ma  = ($urandom_range(0, 99) < 25);
      mr  = ($urandom_range(0, 99) < 50);
      req = ($urandom_range(0, 99) < 10);
      val = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 99) < 2);
      cyc(r, hz, br, ma, mr, req, val, clr);
    end

    #5;
    stim_done = 1'b1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover expectations, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
